// File: rtl/gol_engine_if.sv
// gol_engine_if: command, load, pixel-lookup and status signals between the VGA top level and gol_engine.
interface gol_engine_if;
  logic        frame_tick;
  logic        cmd_run;
  logic        cmd_step;
  logic        cmd_clear;
  logic        cmd_seed;
  logic        wrap_en;
  logic        load_en;
  logic [7:0]  load_x;
  logic [7:0]  load_y;
  logic        load_val;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        cell_alive;
  logic        busy;
  logic        running;
  logic [15:0] gen_count;
  modport master (
    output frame_tick, cmd_run, cmd_step, cmd_clear, cmd_seed, wrap_en,
    output load_en, load_x, load_y, load_val, x_pos, y_pos,
    input  cell_alive, busy, running, gen_count
  );
  modport slave (
    input  frame_tick, cmd_run, cmd_step, cmd_clear, cmd_seed, wrap_en,
    input  load_en, load_x, load_y, load_val, x_pos, y_pos,
    output cell_alive, busy, running, gen_count
  );
endinterface

// File: rtl/gol_engine.sv
// gol_engine: parametrised Game of Life core; one cell per clock into a shadow grid, atomic commit,
// with run pacing, single-step, clear, LFSR seeding, direct load and registered pixel lookup.
module gol_engine #(
  parameter int          GRID_W     = 20,
  parameter int          GRID_H     = 15,
  parameter int          CELL_SHIFT = 5,
  parameter int          GEN_DIV    = 30,
  parameter logic [15:0] LFSR_INIT  = 16'hACE1
) (
  input logic       clk,
  input logic       reset,
  gol_engine_if.slave bus
);
  localparam int N  = GRID_W * GRID_H;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SWEEP, SEED, COMMIT} state_e;
  state_e         state_q;
  logic [N-1:0]   cur_q, nxt_q;
  logic [IW-1:0]  idx_q;
  logic [7:0]     col_q, row_q;
  logic [15:0]    lfsr_q, gen_q;
  logic [FW-1:0]  fcnt_q;
  logic           wrap_q, seed_q, running_q, cell_q;
  logic [7:0]     cm, cp, rm, rp, nb;
  logic           cmv, cpv, rmv, rpv;
  logic [3:0]     n;
  logic           alive_d, disp_d, trig_run, trig, ld_ok, last, col_end;
  logic [9:0]     dc, dr;
  function automatic logic at(input logic [7:0] r, input logic [7:0] c);
    return cur_q[IW'(int'(r) * GRID_W + int'(c))];
  endfunction
  // Neighbour columns/rows always wrap for addressing; the valid flags kill them at dead edges.
  always_comb begin
    cm = (col_q == 8'd0) ? 8'(GRID_W - 1) : col_q - 8'd1;
    cp = (col_q == 8'(GRID_W - 1)) ? 8'd0 : col_q + 8'd1;
    rm = (row_q == 8'd0) ? 8'(GRID_H - 1) : row_q - 8'd1;
    rp = (row_q == 8'(GRID_H - 1)) ? 8'd0 : row_q + 8'd1;
    cmv = wrap_q | (col_q != 8'd0);
    cpv = wrap_q | (col_q != 8'(GRID_W - 1));
    rmv = wrap_q | (row_q != 8'd0);
    rpv = wrap_q | (row_q != 8'(GRID_H - 1));
    nb = {at(rm, cm) & rmv & cmv, at(rm, col_q) & rmv, at(rm, cp) & rmv & cpv,
          at(row_q, cm) & cmv, at(row_q, cp) & cpv,
          at(rp, cm) & rpv & cmv, at(rp, col_q) & rpv, at(rp, cp) & rpv & cpv};
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, nb[k]};
    alive_d = (n == 4'd3) | (cur_q[idx_q] & (n == 4'd2));
    dc = bus.x_pos >> CELL_SHIFT;
    dr = bus.y_pos >> CELL_SHIFT;
    disp_d = (int'(dc) < GRID_W && int'(dr) < GRID_H) ? cur_q[IW'(int'(dr) * GRID_W + int'(dc))] : 1'b0;
    trig_run = running_q & bus.frame_tick & (fcnt_q == FW'(GEN_DIV - 1));
    trig = (bus.cmd_step & ~running_q) | trig_run;
    ld_ok = bus.load_en & ~bus.cmd_step & ~bus.cmd_run &
            (int'(bus.load_x) < GRID_W) & (int'(bus.load_y) < GRID_H);
    col_end = col_q == 8'(GRID_W - 1);
    last = col_end & (row_q == 8'(GRID_H - 1));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      nxt_q     <= '0;
      idx_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      lfsr_q    <= LFSR_INIT;
      gen_q     <= '0;
      fcnt_q    <= '0;
      wrap_q    <= 1'b0;
      seed_q    <= 1'b0;
      running_q <= 1'b0;
      cell_q    <= 1'b0;
    end else begin
      cell_q <= disp_d;
      if (bus.cmd_clear) begin
        state_q   <= IDLE;
        cur_q     <= '0;
        nxt_q     <= '0;
        gen_q     <= '0;
        fcnt_q    <= '0;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            idx_q <= '0;
            col_q <= '0;
            row_q <= '0;
            if (bus.cmd_seed) begin
              state_q <= SEED;
              seed_q  <= 1'b1;
            end else if (trig) begin
              state_q <= SWEEP;
              seed_q  <= 1'b0;
              wrap_q  <= bus.wrap_en;
            end else if (ld_ok)
              cur_q[IW'(int'(bus.load_y) * GRID_W + int'(bus.load_x))] <= bus.load_val;
            if (running_q & bus.frame_tick & ~bus.cmd_seed) fcnt_q <= trig_run ? '0 : fcnt_q + FW'(1);
          end
          SWEEP, SEED: begin
            nxt_q[idx_q] <= (state_q == SEED) ? lfsr_q[0] : alive_d;
            if (state_q == SEED) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            idx_q <= idx_q + IW'(1);
            col_q <= col_end ? 8'd0 : col_q + 8'd1;
            row_q <= col_end ? row_q + 8'd1 : row_q;
            if (last) state_q <= COMMIT;
          end
          default: begin
            cur_q   <= nxt_q;
            gen_q   <= seed_q ? 16'd0 : gen_q + 16'd1;
            state_q <= IDLE;
          end
        endcase
        if (bus.cmd_run) begin
          running_q <= ~running_q;
          fcnt_q    <= '0;
        end
      end
    end
  end
  assign bus.cell_alive = cell_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.running    = running_q;
  assign bus.gen_count  = gen_q;
endmodule

// File: tb/tb_gol_engine.sv
// tb_gol_engine: scoreboard bench for gol_engine; a software grid/Life/LFSR model feeds expected pixels
// into a queue that a monitor pops one cycle after each lookup.
module tb_gol_engine;
  localparam int W = 20, H = 15;
  typedef struct {int x; int y; logic v;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  gol_engine_if bus();
  gol_engine dut (.clk(clk), .reset(reset), .bus(bus));
  exp_t q[$];
  bit   m[0:H-1][0:W-1];
  int   n_vec = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) if (q.size() != 0) begin
    exp_t e;
    #1;
    e = q.pop_front();
    chk($sformatf("pixel(%0d,%0d)", e.x, e.y), 32'(bus.cell_alive), 32'(e.v));
  end
  task automatic pulse(input int k);
    @(negedge clk);
    case (k)
      0: bus.cmd_step = 1'b1;
      1: bus.cmd_clear = 1'b1;
      2: bus.cmd_seed = 1'b1;
      3: bus.cmd_run = 1'b1;
      default: bus.frame_tick = 1'b1;
    endcase
    @(negedge clk);
    {bus.cmd_step, bus.cmd_clear, bus.cmd_seed, bus.cmd_run, bus.frame_tick} = '0;
  endtask
  task automatic load(input int x, input int y, input bit v);
    @(negedge clk);
    bus.load_en = 1'b1;
    bus.load_x = x[7:0];
    bus.load_y = y[7:0];
    bus.load_val = v;
    @(negedge clk);
    bus.load_en = 1'b0;
    if (x < W && y < H) m[y][x] = v;
  endtask
  task automatic wait_idle(input string tag, input int exp_len);
    int len = 0;
    while (bus.busy && len < 2000) begin
      len++;
      @(negedge clk);
    end
    chk(tag, 32'(len), 32'(exp_len));
  endtask
  task automatic probe(input int x, input int y, input bit v);
    @(negedge clk);
    bus.x_pos = 10'(x);
    bus.y_pos = 10'(y);
    q.push_back('{x, y, v});
    repeat (2) @(negedge clk);
  endtask
  task automatic check_grid();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        @(negedge clk);
        bus.x_pos = 10'(c * 32 + 7);
        bus.y_pos = 10'(r * 32 + 19);
        q.push_back('{c * 32 + 7, r * 32 + 19, m[r][c]});
      end
    repeat (2) @(negedge clk);
  endtask
  task automatic life(input bit wrap);
    bit t[0:H-1][0:W-1];
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr, cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (wrap) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) continue;
            n += int'(m[rr][cc]);
          end
        t[r][c] = (n == 3) || (m[r][c] && n == 2);
      end
    m = t;
  endtask
  task automatic clear_model();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) m[r][c] = 1'b0;
  endtask
  task automatic seed_model();
    logic [15:0] l = 16'hACE1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        m[r][c] = l[0];
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
  endtask
  task automatic corners(input bit wrap);
    pulse(1);
    clear_model();
    load(0, 0, 1); load(19, 0, 1); load(0, 14, 1); load(19, 14, 1);
    bus.wrap_en = wrap;
    pulse(0);
    wait_idle(wrap ? "wrap_busy" : "dead_busy", 301);
    chk("corner_gen", 32'(bus.gen_count), 32'd1);
    life(wrap);
    check_grid();
    bus.wrap_en = 1'b1;
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    {bus.cmd_step, bus.cmd_clear, bus.cmd_seed, bus.cmd_run, bus.frame_tick, bus.load_en} = '0;
    bus.wrap_en = 1'b1;
    bus.load_x = '0; bus.load_y = '0; bus.load_val = 1'b0;
    bus.x_pos = '0; bus.y_pos = '0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_gen", 32'(bus.gen_count), 32'd0);
    chk("rst_cell", 32'(bus.cell_alive), 32'd0);
    reset = 1'b0;
    check_grid();
    load(5, 5, 1); load(6, 5, 1); load(7, 5, 1);
    probe(200, 170, 1);
    pulse(0);
    wait_idle("blinker_busy", 301);
    chk("blinker_gen1", 32'(bus.gen_count), 32'd1);
    life(1);
    check_grid();
    probe(200, 140, 1);
    probe(170, 170, 0);
    pulse(0);
    wait_idle("blinker_busy2", 301);
    chk("blinker_gen2", 32'(bus.gen_count), 32'd2);
    life(1);
    check_grid();
    load(20, 3, 1); load(3, 15, 1); load(255, 255, 1);
    probe(650, 100, 0);
    probe(100, 490, 0);
    probe(1023, 1023, 0);
    check_grid();
    corners(1);
    probe(5, 5, 1);
    probe(19 * 32 + 5, 14 * 32 + 5, 1);
    corners(0);
    pulse(1);
    clear_model();
    load(5, 5, 1); load(6, 5, 1); load(7, 5, 1);
    pulse(3);
    chk("run_on", 32'(bus.running), 32'd1);
    for (int i = 0; i < 90; i++) begin
      pulse(4);
      repeat (400) @(negedge clk);
    end
    chk("run_gen3", 32'(bus.gen_count), 32'd3);
    life(1); life(1); life(1);
    check_grid();
    pulse(3);
    chk("run_off", 32'(bus.running), 32'd0);
    for (int i = 0; i < 60; i++) begin
      pulse(4);
      repeat (20) @(negedge clk);
    end
    chk("stopped_gen3", 32'(bus.gen_count), 32'd3);
    chk("stopped_busy", 32'(bus.busy), 32'd0);
    pulse(0);
    repeat (100) @(negedge clk);
    chk("mid_sweep_busy", 32'(bus.busy), 32'd1);
    pulse(1);
    chk("clear_busy", 32'(bus.busy), 32'd0);
    chk("clear_gen", 32'(bus.gen_count), 32'd0);
    clear_model();
    check_grid();
    pulse(0);
    wait_idle("empty_busy", 301);
    chk("empty_gen", 32'(bus.gen_count), 32'd1);
    check_grid();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    pulse(2);
    wait_idle("seed_busy", 301);
    chk("seed_gen", 32'(bus.gen_count), 32'd0);
    seed_model();
    probe(5, 5, 1);
    check_grid();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    pulse(2);
    wait_idle("reseed_busy", 301);
    check_grid();
    pulse(0);
    wait_idle("seed_life_busy", 301);
    chk("seed_life_gen", 32'(bus.gen_count), 32'd1);
    life(1);
    check_grid();
    load(0, 0, 1);
    probe(5, 5, 1);
    pulse(3);
    chk("pre_rst_running", 32'(bus.running), 32'd1);
    pulse(2);
    repeat (50) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_running", 32'(bus.running), 32'd0);
    chk("async_gen", 32'(bus.gen_count), 32'd0);
    chk("async_cell", 32'(bus.cell_alive), 32'd0);
    @(negedge clk) reset = 1'b0;
    clear_model();
    check_grid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gol_engine.md
# gol_engine

- Parametrised Game of Life core that supersedes the fixed-size engine in the VGA top level.
- Holds a W×H cell grid in registers and computes one generation by sweeping one cell per clock into a shadow buffer, then commits atomically.
- Answers pixel lookups from the VGA controller's x/y position.
- Adds over the fixed engine:
  - toroidal or dead-edge boundary
  - frame-paced run mode and single-step
  - clear, LFSR seeding, direct cell load
  - generation counter

## Interface
Parameters:
- GRID_W, 20, grid columns (≤256)
- GRID_H, 15, grid rows (≤256)
- CELL_SHIFT, 5, log2 of cell size in pixels (20×15 cells of 32 px = 640×480)
- GEN_DIV, 30, frame ticks per generation in run mode (≥1)
- LFSR_INIT, 16'hACE1, seed LFSR reset value (nonzero)

Ports:
- clk  in  1  single clock (25 MHz pixel clock)
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame
- cmd_run  in  1  pulse; toggles `running`
- cmd_step  in  1  pulse; one generation when idle and not running
- cmd_clear  in  1  pulse; zero grid
- cmd_seed  in  1  pulse; fill grid from LFSR
- wrap_en  in  1  1 = toroidal edges, 0 = outside cells dead
- load_en  in  1  write one cell (honoured only in IDLE)
- load_x  in  8  cell column
- load_y  in  8  cell row
- load_val  in  1  cell value
- x_pos  in  10  pixel column
- y_pos  in  10  pixel row
- cell_alive  out  1  registered state of the cell under (x_pos, y_pos)
- busy  out  1  sweep, seed or commit in progress
- running  out  1  run mode active
- gen_count  out  16  generations committed since clear/seed/reset

## Operation
- Storage: `cur` and `nxt` arrays, GRID_W*GRID_H bits each. Display and neighbour logic read only `cur`.
- State machine: IDLE, SWEEP, SEED, COMMIT.
- IDLE command priority (same cycle): clear > seed > step/run-trigger > load.
  - cmd_clear zeroes `cur`, `nxt`, `gen_count`, `running` and the frame counter in one cycle. It is also honoured in any state: it aborts the sweep/seed, returns to IDLE and does not increment `gen_count`.
  - cmd_seed → SEED.
  - cmd_step with running=0 → SWEEP.
  - running=1 and frame_tick with frame counter = GEN_DIV-1 → SWEEP, frame counter ← 0. Otherwise a frame_tick while running increments the frame counter.
- cmd_run toggles `running` in any state and zeroes the frame counter. cmd_step, cmd_seed and load_en outside IDLE are ignored. Frame ticks during busy are not counted.
- SWEEP:
  - Index runs raster order (col 0..GRID_W-1 inner, row outer), one cell per cycle.
  - `wrap_en` is latched at SWEEP entry.
  - Neighbour count n (0..8, 4-bit) is taken over the 8 neighbours in `cur`. With wrap, col -1 → GRID_W-1, col GRID_W → 0, likewise rows; without wrap, out-of-grid neighbours count 0.
  - nxt[i] ← (n==3) | (cur[i] & n==2).
  - After the last cell → COMMIT.
- SEED: same raster sweep; nxt[i] ← lfsr[0], and the LFSR advances every cell. Polynomial x^16+x^14+x^13+x^11+1, Fibonacci, shift left, feedback = l[15]^l[13]^l[12]^l[10]. After the last cell → COMMIT.
- COMMIT (1 cycle): cur ← nxt. The sweep path increments `gen_count` (wraps FFFF→0000); the seed path sets it to 0. Then → IDLE.
- Load: in IDLE with no command, if load_x<GRID_W and load_y<GRID_H, cur[load_y][load_x] ← load_val. Out-of-range loads are dropped.
- Display: col = x_pos>>CELL_SHIFT, row = y_pos>>CELL_SHIFT. cell_alive ← (col<GRID_W & row<GRID_H) ? cur[row][col] : 0.

## Timing
- Reset values:
  - `cur`, `nxt` = 0; state IDLE; lfsr = LFSR_INIT
  - cell_alive = 0, busy = 0, running = 0, gen_count = 0, frame counter = 0
- cell_alive latency: 1 cycle from x_pos/y_pos.
- Display never tears: `cur` changes only in COMMIT, clear, or load.
- Trigger at cycle T:
  - busy = 1 from T+1 through T+N+1, with N = GRID_W*GRID_H.
  - COMMIT occurs at cycle T+N+1.
  - gen_count and cell_alive-visible grid update at T+N+2.
  - A new trigger is accepted at T+N+2.
- Clear: takes effect the cycle after the pulse; busy = 0 in that same cycle.
- Load: visible on cell_alive two cycles after load_en.
- Reset asserted mid-sweep: all state returns to reset values immediately (asynchronous).

## Test plan
- Reset mid-run → cell_alive=0 for all pixels, gen_count=0, busy=0, running=0 immediately.
- Blinker: load (5,5),(6,5),(7,5), cmd_step → busy for 301 cycles; gen_count=1. Alive exactly (6,4),(6,5),(6,6), e.g. pixel (200,140)=1 and (170,170)=0. A second step restores the horizontal line with gen_count=2.
- Boundary: load corners (0,0),(19,0),(0,14),(19,14).
  - wrap_en=1, step → all four alive, grid otherwise empty.
  - wrap_en=0, step → grid empty, gen_count=1.
- Run pacing: cmd_run, 90 frame_ticks spaced ≥400 cycles apart → gen_count=3. cmd_run again, 60 more ticks → gen_count stays 3.
- Clear mid-sweep: cmd_clear 100 cycles into a step → next cycle busy=0, grid empty, gen_count=0. A following cmd_step yields gen_count=1 on an empty grid.
- Seed: cmd_seed after reset → busy 301 cycles, gen_count=0. cur[0][0] = bit0 of 16'hACE1 = 1. Pattern is bit-exact against a software LFSR model and repeats identically after reset.
